// File: rtl/mmp_iddmm_pkg.sv
// rtl/mmp_iddmm_pkg.sv - shared sizes and final-subtract state encoding for the IDDMM multiplier
package mmp_iddmm_pkg;

  localparam int MMP_N      = 32;
  localparam int MMP_K      = 128;
  localparam int MMP_ADDR_W = $clog2(MMP_N);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DEC,
    WRITE,
    DONE
  } finalsub_state_e;

endpackage

// File: rtl/mmp_iddmm_finalsub_if.sv
// rtl/mmp_iddmm_finalsub_if.sv - controller handshake plus A/M RAM ports of the final-subtract stage
interface mmp_iddmm_finalsub_if
  import mmp_iddmm_pkg::*;
#(
  parameter int K      = MMP_K,
  parameter int ADDR_W = MMP_ADDR_W
);

  logic              comp_req;
  logic              comp_end;
  logic              ref_an;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ena;
  logic [K-1:0]      rd_a_data;
  logic [K-1:0]      rd_m_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [K-1:0]      wr_data;
  logic              wr_ena;
  logic              sub_taken;

  modport slave (
    input  comp_req, ref_an, rd_a_data, rd_m_data,
    output comp_end, rd_addr, rd_ena, wr_addr, wr_data, wr_ena, sub_taken
  );

  modport master (
    output comp_req, ref_an, rd_a_data, rd_m_data,
    input  comp_end, rd_addr, rd_ena, wr_addr, wr_data, wr_ena, sub_taken
  );

endinterface

// File: rtl/mmp_iddmm_sub_word.sv
// rtl/mmp_iddmm_sub_word.sv - combinational K-bit subtract with borrow in and borrow out
module mmp_iddmm_sub_word
  import mmp_iddmm_pkg::*;
#(
  parameter int K = MMP_K
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         bin,
  output logic [K-1:0] diff,
  output logic         bout
);

  // The extra top bit of the widened difference goes to 1 exactly when a < b + bin.
  assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{K{1'b0}}, bin};

endmodule

// File: rtl/mmp_iddmm_finalsub.sv
// rtl/mmp_iddmm_finalsub.sv - conditional final subtraction {an,A} >= M ? A-M : A, written back in place
// Optional MMP_FINALSUB_CONST_TIME_EN: always run the write pass so latency does not depend on the result.
module mmp_iddmm_finalsub
  import mmp_iddmm_pkg::*;
#(
  parameter int N      = MMP_N,
  parameter int K      = MMP_K,
  parameter int ADDR_W = MMP_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mmp_iddmm_finalsub_if.slave   bus
);

  localparam logic [ADDR_W:0]   CNT_END   = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N - 1);

  finalsub_state_e   state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              an_q, an_d;
  logic              borrow_q, borrow_d;
  logic              rvld_q, rvld_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              sub_taken_q, sub_taken_d;
  logic              wr_ena_q, wr_ena_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [K-1:0]      wr_data_q, wr_data_d;

  logic              rd_ena;
  logic [ADDR_W-1:0] rd_addr;
  logic [K-1:0]      diff;
  logic              bout;
  logic              take;
  logic              last_word;

  mmp_iddmm_sub_word #(.K(K)) u_sub_word (
    .a    (bus.rd_a_data),
    .b    (bus.rd_m_data),
    .bin  (borrow_q),
    .diff (diff),
    .bout (bout)
  );

  assign rd_ena    = ((state_q == SCAN) || (state_q == WRITE)) && (cnt_q < CNT_END);
  assign rd_addr   = rd_ena ? cnt_q[ADDR_W-1:0] : '0;
  assign take      = an_q | ~borrow_q;
  assign last_word = rvld_q && (raddr_q == ADDR_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    an_d        = an_q;
    borrow_d    = borrow_q;
    sub_taken_d = sub_taken_q;
    rvld_d      = rd_ena;
    raddr_d     = rd_addr;
    wr_ena_d    = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.comp_req) begin
          state_d     = SCAN;
          an_d        = bus.ref_an;
          cnt_d       = '0;
          borrow_d    = 1'b0;
          sub_taken_d = 1'b0;
        end
      end
      SCAN: begin
        if (rd_ena) cnt_d = cnt_q + 1'b1;
        if (rvld_q) borrow_d = bout;
        if (last_word) state_d = DEC;
      end
      DEC: begin
        sub_taken_d = take;
        cnt_d       = '0;
        borrow_d    = 1'b0;
`ifdef MMP_FINALSUB_CONST_TIME_EN
        state_d     = WRITE;
`else
        state_d     = take ? WRITE : DONE;
`endif
      end
      WRITE: begin
        if (rd_ena) cnt_d = cnt_q + 1'b1;
        if (rvld_q) begin
          borrow_d  = bout;
          wr_ena_d  = 1'b1;
          wr_addr_d = raddr_q;
`ifdef MMP_FINALSUB_CONST_TIME_EN
          wr_data_d = sub_taken_q ? diff : bus.rd_a_data;
`else
          wr_data_d = diff;
`endif
        end
        // Writes are registered, so the pass ends once the top word is on the write port.
        if (wr_ena_q && (wr_addr_q == ADDR_LAST)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      an_q        <= 1'b0;
      borrow_q    <= 1'b0;
      rvld_q      <= 1'b0;
      raddr_q     <= '0;
      sub_taken_q <= 1'b0;
      wr_ena_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      an_q        <= an_d;
      borrow_q    <= borrow_d;
      rvld_q      <= rvld_d;
      raddr_q     <= raddr_d;
      sub_taken_q <= sub_taken_d;
      wr_ena_q    <= wr_ena_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.comp_end  = (state_q == DONE);
  assign bus.rd_ena    = rd_ena;
  assign bus.rd_addr   = rd_addr;
  assign bus.wr_ena    = wr_ena_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.sub_taken = sub_taken_q;

endmodule

// File: tb/tb_mmp_iddmm_finalsub.sv
// tb/tb_mmp_iddmm_finalsub.sv - randomized and directed checks of the final subtraction against an integer model
module tb_mmp_iddmm_finalsub;

  localparam int N      = 4;
  localparam int K      = 8;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  logic [K-1:0] a_mem [N];
  logic [K-1:0] m_mem [N];
  logic [K-1:0] a_ld  [N];
  logic [K-1:0] m_ld  [N];
  logic         ld = 1'b0;

  mmp_iddmm_finalsub_if #(.K(K), .ADDR_W(ADDR_W)) bus ();

  mmp_iddmm_finalsub #(.N(N), .K(K), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Read-before-write RAM pair with one-cycle read latency.
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < N; i++) begin
        a_mem[i] <= a_ld[i];
        m_mem[i] <= m_ld[i];
      end
    end else if (bus.wr_ena) begin
      a_mem[bus.wr_addr] <= bus.wr_data;
    end
    if (bus.rd_ena) begin
      bus.rd_a_data <= a_mem[bus.rd_addr];
      bus.rd_m_data <= m_mem[bus.rd_addr];
    end
  end

  function automatic logic [31:0] a_image();
    logic [31:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = a_mem[i];
    return v;
  endfunction

  task automatic load(input logic [31:0] a, input logic [31:0] m);
    for (int i = 0; i < N; i++) begin
      a_ld[i] = a[8*i +: 8];
      m_ld[i] = m[8*i +: 8];
    end
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  task automatic run_op(input logic an, output int lat, output int nwr, output logic took);
    bus.ref_an   = an;
    bus.comp_req = 1'b1;
    lat = 0;
    nwr = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (bus.wr_ena) nwr++;
      if (bus.comp_end) begin
        lat = c;
        break;
      end
    end
    bus.comp_req = 1'b0;
    bus.ref_an   = 1'b0;
    took = bus.sub_taken;
    @(posedge clk); #1;
    chk_cnt++;
    if (bus.comp_end !== 1'b0) $display("FAIL comp_end_pulse got=%b want=0", bus.comp_end);
    else pass_cnt++;
  endtask

  // Whole-number model: reduce when {an,A} >= M, result kept to N*K bits.
  task automatic check_case(input string name, input logic [31:0] a, input logic [31:0] m, input logic an);
    longint unsigned full, mv, res;
    logic            exp_take, took;
    int              exp_lat, exp_wr, lat, nwr;
    logic [31:0]     got;
    full     = {31'd0, an, a};
    mv       = {32'd0, m};
    exp_take = (full >= mv);
    res      = exp_take ? ((full - mv) & 64'hFFFF_FFFF) : {32'd0, a};
`ifdef MMP_FINALSUB_CONST_TIME_EN
    exp_lat = 2 * N + 5;
    exp_wr  = N;
`else
    exp_lat = exp_take ? 2 * N + 5 : N + 3;
    exp_wr  = exp_take ? N : 0;
`endif
    load(a, m);
    run_op(an, lat, nwr, took);
    got = a_image();
    chk_cnt++;
    if (took !== exp_take) $display("FAIL %s take got=%b want=%b", name, took, exp_take);
    else pass_cnt++;
    chk_cnt++;
    if (got !== res[31:0]) $display("FAIL %s result got=%h want=%h", name, got, res[31:0]);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== exp_lat) $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat);
    else pass_cnt++;
    chk_cnt++;
    if (nwr !== exp_wr) $display("FAIL %s writes got=%0d want=%0d", name, nwr, exp_wr);
    else pass_cnt++;
  endtask

  task automatic check_idle_outputs(input string name);
    logic [22:0] got;
    got = {bus.comp_end, bus.rd_ena, bus.rd_addr, bus.wr_ena, bus.wr_addr, bus.wr_data, bus.sub_taken, bus.rd_addr, bus.wr_addr};
    chk_cnt++;
    if (got !== '0) $display("FAIL %s outputs got=%h want=0", name, got);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    bus.comp_req = 1'b0;
    bus.ref_an   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");
  endtask

  task automatic test_directed();
    check_case("sub_taken",  32'h281E_140A, 32'h281E_1405, 1'b0);
    check_case("no_sub",     32'h281E_1404, 32'h281E_1405, 1'b0);
    check_case("equal_ff",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_case("an_forces",  32'h0000_0000, 32'h0000_0001, 1'b1);
    check_case("a_m_minus1", 32'h1234_5677, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, m;
    logic        an;
    for (int i = 0; i < 24; i++) begin
      m  = $urandom;
      an = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = m;
        2:       a = m + 32'($urandom_range(0, 3));
        default: a = m - 32'($urandom_range(1, 3));
      endcase
      check_case($sformatf("rand%0d", i), a, m, an);
    end
  endtask

  task automatic test_reset_mid_write();
    logic seen;
    int   lat, nwr;
    logic took;
    load(32'h281E_140A, 32'h281E_1405);
    bus.ref_an   = 1'b0;
    bus.comp_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.wr_ena && bus.wr_addr == 2'd2) seen = 1'b1;
    end
    chk_cnt++;
    if (!seen) $display("FAIL reset_mid reached_word2 got=0 want=1");
    else pass_cnt++;
    rst_n = 1'b0;
    bus.comp_req = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("reset_mid");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_case("after_reset", 32'h0102_0304, 32'h0102_0300, 1'b0);
    lat = 0; nwr = 0; took = 1'b0;
  endtask

  task automatic test_back_to_back();
    check_case("b2b_0", 32'h0000_00FF, 32'h0000_0100, 1'b0);
    check_case("b2b_1", 32'h0000_0100, 32'h0000_00FF, 1'b0);
  endtask

  initial begin
    bus.comp_req  = 1'b0;
    bus.ref_an    = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
